hbridge_deadtime: RTL and testbench

Safety stage between the APB motor controller and the H-bridge pins. Consumes the controller's 4-bit leg request (h_in1..h_in4) and its PWM. Guarantees that no leg is switched on until every leg has been off for a programmable dead time. Forces illegal shoot-through pairs off and raises a sticky fault.

---
 rtl/hbridge_pkg.sv | 27 ++
 rtl/hbridge_deadtime.sv | 114 +++++++++++
 tb/tb_hbridge_deadtime.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hbridge_pkg.sv
// ============================================================================
// Module  : hbridge_pkg
// Brief   : Shared types and helpers for the H-bridge dead-time safety stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hbridge_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DEAD = 1'b1
    } state_e;

    localparam logic [1:0] COAST = 2'b00;
    localparam logic [1:0] FWD   = 2'b01;
    localparam logic [1:0] REV   = 2'b10;
    localparam logic [1:0] SHOOT = 2'b11;

    // Both switches of one leg pair on at once shorts the supply; force coast.
    function automatic logic [1:0] sanitize_pair(input logic [1:0] pair);
        return (pair == SHOOT) ? COAST : pair;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hbridge_deadtime.sv
// ============================================================================
// Module  : hbridge_deadtime
// Brief   : Shoot-through filter and all-off dead-time enforcer for H-bridge
//           leg drives. Optional PWM gating via HBRIDGE_PWM_GATE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hbridge_deadtime
    import hbridge_pkg::*;
#(
    parameter int DEAD_CYCLES = 5000,
    parameter int CNT_W       = $clog2(DEAD_CYCLES + 1)
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [3:0] req_in,
    input  logic       pwm_in,
    input  logic       fault_clr,
    output logic [3:0] h_out,
    output logic       busy,
    output logic       fault
);

    localparam logic [CNT_W-1:0] c_DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       applied_q, applied_d;
    logic             busy_q;
    logic             fault_q, fault_d;
    logic [3:0]       w_san_req;
    logic             w_illegal;

    always_comb begin
        w_san_req = {sanitize_pair(req_in[3:2]), sanitize_pair(req_in[1:0])};
        w_illegal = (req_in[1:0] == SHOOT) || (req_in[3:2] == SHOOT);
        state_d   = state_q;
        cnt_d     = cnt_q;
        applied_d = applied_q;
        fault_d   = w_illegal | (fault_q & ~fault_clr);

        unique case (state_q)
            RUN: begin
                if (w_san_req != applied_q) begin
                    // Settled all-off may energise at once; anything else
                    // must pass through a full all-off interval first.
                    if (applied_q == 4'b0000) begin
                        applied_d = w_san_req;
                    end else begin
                        applied_d = 4'b0000;
                        cnt_d     = c_DEAD_LOAD;
                        state_d   = DEAD;
                    end
                end
            end
            DEAD: begin
                applied_d = 4'b0000;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    applied_d = w_san_req;
                    state_d   = RUN;
                end
            end
            default: begin
                applied_d = 4'b0000;
                cnt_d     = c_DEAD_LOAD;
                state_d   = DEAD;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q   <= DEAD;
            cnt_q     <= c_DEAD_LOAD;
            applied_q <= 4'b0000;
            busy_q    <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            applied_q <= applied_d;
            busy_q    <= (state_d == DEAD);
            fault_q   <= fault_d;
        end
    end

`ifdef HBRIDGE_PWM_GATE_EN
    logic pwm_q;

    always_ff @(posedge pclk) begin
        if (reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_in;
        end
    end

    assign h_out = applied_q & {4{pwm_q}};
`else
    logic w_unused_pwm;

    assign w_unused_pwm = pwm_in;
    assign h_out        = applied_q;
`endif

    assign busy  = busy_q;
    assign fault = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_hbridge_deadtime.sv
// ============================================================================
// Module  : tb_hbridge_deadtime
// Brief   : Scoreboard bench for hbridge_deadtime (DEAD_CYCLES = 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hbridge_deadtime;

    localparam int c_DC = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       pwm;
    logic       clr;
    logic [3:0] h_out;
    logic       busy;
    logic       fault;

    typedef struct {
        int         cyc;
        logic [3:0] h;
        logic       busy;
        logic       fault;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    bit stim_done = 0;

    // Reference model state: time-stamped dead interval rather than a counter.
    int         k = 0;
    int         m_dead_end = 0;
    logic [3:0] m_app = 4'b0000;
    logic       m_busy = 1'b1;
    logic       m_fault = 1'b0;
    logic       m_pwm = 1'b0;

    hbridge_deadtime #(.DEAD_CYCLES(c_DC)) dut (
        .pclk      (clk),
        .reset     (rst),
        .req_in    (req),
        .pwm_in    (pwm),
        .fault_clr (clr),
        .h_out     (h_out),
        .busy      (busy),
        .fault     (fault)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_san(input logic [3:0] r);
        logic [3:0] s;
        s = r;
        if (r[1:0] == 2'b11) s[1:0] = 2'b00;
        if (r[3:2] == 2'b11) s[3:2] = 2'b00;
        return s;
    endfunction

    // Drive one cycle of inputs (before the next rising edge) and push the
    // outputs expected right after that edge.
    task automatic step(input logic [3:0] r, input logic c, input logic rs, input logic p);
        logic [3:0] s;
        exp_t       e;
        @(negedge clk);
        req = r; clr = c; rst = rs; pwm = p;
        k++;
        if (rs) begin
            m_app = 4'b0000; m_dead_end = k + c_DC; m_busy = 1'b1;
            m_fault = 1'b0;  m_pwm = 1'b0;
        end else begin
            s = model_san(r);
            if (k < m_dead_end) begin
                m_app = 4'b0000; m_busy = 1'b1;
            end else if (s == m_app) begin
                m_busy = 1'b0;
            end else if (m_app == 4'b0000) begin
                m_app = s; m_busy = 1'b0;
            end else begin
                m_app = 4'b0000; m_dead_end = k + c_DC; m_busy = 1'b1;
            end
            if ((r[1:0] == 2'b11) || (r[3:2] == 2'b11)) m_fault = 1'b1;
            else if (c) m_fault = 1'b0;
            m_pwm = p;
        end
        e.cyc = k;
`ifdef HBRIDGE_PWM_GATE_EN
        e.h = m_app & {4{m_pwm}};
`else
        e.h = m_app;
`endif
        e.busy  = m_busy;
        e.fault = m_fault;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                if (h_out !== e.h) begin
                    fails++;
                    $display("FAIL h_out cyc=%0d got=%b exp=%b", e.cyc, h_out, e.h);
                end
                tests++;
                if (busy !== e.busy) begin
                    fails++;
                    $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, busy, e.busy);
                end
                tests++;
                if (fault !== e.fault) begin
                    fails++;
                    $display("FAIL fault cyc=%0d got=%b exp=%b", e.cyc, fault, e.fault);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] r;
        logic       p;
        int         hold;
        rst = 1'b1; req = 4'b0000; clr = 1'b0; pwm = 1'b0;

        // Reset release with a request pending.
        step(4'b0001, 1'b0, 1'b1, 1'b1);
        step(4'b0001, 1'b0, 1'b1, 1'b1);
        repeat (6) step(4'b0001, 1'b0, 1'b0, 1'b1);
        // Turn-off, then settled-off turn-on.
        repeat (6) step(4'b0000, 1'b0, 1'b0, 1'b1);
        repeat (3) step(4'b0101, 1'b0, 1'b0, 1'b1);
        repeat (6) step(4'b0000, 1'b0, 1'b0, 1'b1);
        // Reversal with a mid-dead-time request change.
        repeat (3) step(4'b0001, 1'b0, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b0, 1'b1);
        repeat (6) step(4'b1000, 1'b0, 1'b0, 1'b1);
        // Illegal pair, sticky fault, clear, and set-beats-clear.
        repeat (8) step(4'b0111, 1'b0, 1'b0, 1'b1);
        repeat (2) step(4'b0100, 1'b0, 1'b0, 1'b1);
        step(4'b0100, 1'b1, 1'b0, 1'b1);
        step(4'b1101, 1'b1, 1'b0, 1'b1);
        repeat (6) step(4'b0100, 1'b0, 1'b0, 1'b1);
        // Reset while energised.
        repeat (6) step(4'b1010, 1'b0, 1'b0, 1'b1);
        step(4'b1010, 1'b0, 1'b1, 1'b1);
        repeat (6) step(4'b1010, 1'b0, 1'b0, 1'b1);
        // PWM square wave on a steady leg, then a reversal.
        repeat (6) step(4'b0001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b0, 1'b0, i[1]);
        repeat (8) step(4'b0010, 1'b0, 1'b0, 1'b1);

        // Randomised segments.
        p = 1'b1;
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 9) == 0) r = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0) r = 4'b0000;
            else r = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 3) == 0) p = ~p;
                step(r, ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 99) == 0), p);
            end
        end
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        stim_done = 1;

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
